// File: rtl/sap_trace_buffer.sv
// Trigger-driven trace buffer for the SAP CPU: samples bus/control/MAR/IR into a
// ring while armed, freezes a fixed number of samples after a control-word match, then drains.
module sap_trace_buffer #(
    parameter int BUS_W        = 8,
    parameter int CTRL_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int DEPTH        = 16,
    parameter int POST_SAMPLES = 4,
    parameter int REC_W        = 1 + ADDR_W + 2 * BUS_W + CTRL_W,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [BUS_W-1:0]  bus,
    input  logic [CTRL_W-1:0] ctrl_state,
    input  logic [ADDR_W-1:0] mem_address_data,
    input  logic [BUS_W-1:0]  instruction_data,
    input  logic              arm,
    input  logic [CTRL_W-1:0] trig_mask,
    input  logic [CTRL_W-1:0] trig_value,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [REC_W-1:0]  rd_data,
    output logic              rd_last,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  fill
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [REC_W-1:0]   mem_q [DEPTH];

    logic               match_s;
    logic               flag_s;
    logic               wr_en_s;
    logic [CNT_W-1:0]   fill_inc_s;
    logic [REC_W-1:0]   sample_s;
    logic               rd_valid_s;

    assign match_s    = ((ctrl_state & trig_mask) == (trig_value & trig_mask));
    assign sample_s   = {flag_s, mem_address_data, instruction_data, bus, ctrl_state};
    // Once the ring is full, new samples overwrite the oldest and the count stays at DEPTH.
    assign fill_inc_s = (fill_q == CNT_W'(DEPTH)) ? fill_q : fill_q + CNT_W'(1);
    assign rd_valid_s = (state_q == ST_DRAIN) && (fill_q != {CNT_W{1'b0}});

    // Next-state, pointer and counter logic for the capture/drain sequence.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        post_d   = post_q;
        wr_en_s  = 1'b0;
        flag_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    fill_d   = {CNT_W{1'b0}};
                    wr_ptr_d = {PTR_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ARMED: begin
                wr_en_s  = 1'b1;
                flag_s   = match_s;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                fill_d   = fill_inc_s;
                if (match_s) begin
                    if (POST_SAMPLES == 0) begin
                        state_d  = ST_DRAIN;
                        rd_ptr_d = wr_ptr_d - fill_d[PTR_W-1:0];
                    end else begin
                        state_d  = ST_POST;
                        post_d   = CNT_W'(POST_SAMPLES);
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_POST: begin
                wr_en_s  = 1'b1;
                flag_s   = 1'b0;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                fill_d   = fill_inc_s;
                post_d   = post_q - CNT_W'(1);
                if (post_q <= CNT_W'(1)) begin
                    // Oldest record sits fill entries behind the frozen write pointer.
                    state_d  = ST_DRAIN;
                    rd_ptr_d = wr_ptr_d - fill_d[PTR_W-1:0];
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_DRAIN: begin
                if (rd_valid_s && rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    fill_d   = fill_q - CNT_W'(1);
                    if (fill_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (!rd_valid_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            fill_q   <= {CNT_W{1'b0}};
            post_q   <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            post_q   <= post_d;
        end
    end

    // Sample storage; contents survive clear and are never read outside a drain.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= sample_s;
        end
    end

    assign rd_valid = rd_valid_s;
    assign rd_data  = rd_valid_s ? mem_q[rd_ptr_q] : {REC_W{1'b0}};
    assign rd_last  = rd_valid_s && (fill_q == CNT_W'(1));
    assign state    = state_q;
    assign fill     = fill_q;

endmodule

// File: tb/tb_sap_trace_buffer.sv
// Randomized bench for sap_trace_buffer: a queue of expected records (last DEPTH samples
// written) is compared against what the buffer drains, plus state/fill checks throughout.
module tb_sap_trace_buffer;

    localparam int BUS_W  = 8;
    localparam int CTRL_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int POST   = 4;
    localparam int REC_W  = 1 + ADDR_W + 2 * BUS_W + CTRL_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              clr;
    logic [BUS_W-1:0]  bus;
    logic [CTRL_W-1:0] ctrl_state;
    logic [ADDR_W-1:0] mem_address_data;
    logic [BUS_W-1:0]  instruction_data;
    logic              arm, arm0;
    logic [CTRL_W-1:0] trig_mask, trig_value;
    logic              rd_ready, rd_ready0;
    logic              rd_valid, rd_valid0;
    logic [REC_W-1:0]  rd_data, rd_data0;
    logic              rd_last, rd_last0;
    logic [1:0]        state, state0;
    logic [CNT_W-1:0]  fill, fill0;

    sap_trace_buffer #(.BUS_W(BUS_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W),
                       .DEPTH(DEPTH), .POST_SAMPLES(POST)) dut (
        .clk(clk), .clr(clr), .bus(bus), .ctrl_state(ctrl_state),
        .mem_address_data(mem_address_data), .instruction_data(instruction_data),
        .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .fill(fill));

    sap_trace_buffer #(.BUS_W(BUS_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W),
                       .DEPTH(DEPTH), .POST_SAMPLES(0)) dut0 (
        .clk(clk), .clr(clr), .bus(bus), .ctrl_state(ctrl_state),
        .mem_address_data(mem_address_data), .instruction_data(instruction_data),
        .arm(arm0), .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_ready(rd_ready0), .rd_valid(rd_valid0), .rd_data(rd_data0),
        .rd_last(rd_last0), .state(state0), .fill(fill0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    logic [REC_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_taps(input logic [CTRL_W-1:0] c);
        bus              = BUS_W'($urandom);
        mem_address_data = ADDR_W'($urandom);
        instruction_data = BUS_W'($urandom);
        ctrl_state       = c;
    endtask

    function automatic logic [REC_W-1:0] rec(input logic f);
        return {f, mem_address_data, instruction_data, bus, ctrl_state};
    endfunction

    task automatic push(input logic [REC_W-1:0] r);
        exp_q.push_back(r);
        if (exp_q.size() > DEPTH) exp_q.delete(0);
    endtask

    function automatic logic [CTRL_W-1:0] nonmatch();
        logic [CTRL_W-1:0] c;
        do c = CTRL_W'($urandom); while ((c & trig_mask) == (trig_value & trig_mask));
        return c;
    endfunction

    // Arm, write n_pre non-matching samples, a trigger sample, then POST samples.
    task automatic capture(input int n_pre, input bit directed, input bit arm_noise);
        logic [CTRL_W-1:0] c;
        exp_q.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_state", 64'(state), 64'd1);
        chk("arm_fill", 64'(fill), 64'd0);
        for (int i = 0; i < n_pre; i++) begin
            c = directed ? CTRL_W'(i) : nonmatch();
            drive_taps(c);
            push(rec(1'b0));
            arm = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            chk("pre_state", 64'(state), 64'd1);
            chk("pre_fill", 64'(fill), 64'(exp_q.size()));
        end
        c = trig_value | (CTRL_W'($urandom) & ~trig_mask);
        drive_taps(c);
        push(rec(1'b1));
        arm = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        chk("trig_state", 64'(state), 64'd2);
        chk("trig_fill", 64'(fill), 64'(exp_q.size()));
        for (int j = 0; j < POST; j++) begin
            c = ($urandom_range(0, 2) == 0) ? trig_value : CTRL_W'($urandom);
            drive_taps(c);
            push(rec(1'b0));
            arm = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            chk("post_state", 64'(state), (j == POST - 1) ? 64'd3 : 64'd2);
            chk("post_fill", 64'(fill), 64'(exp_q.size()));
        end
        arm = 1'b0;
    endtask

    // mode 0: always ready, 1: 1,0,0,1,0,1 pattern, 2: random ready.
    task automatic drain(input int mode);
        int cyc = 0;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[cyc % 6];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            arm = 1'($urandom_range(0, 1));
            chk("dr_valid", 64'(rd_valid), 64'd1);
            chk("dr_data", 64'(rd_data), 64'(exp_q[0]));
            chk("dr_last", 64'(rd_last), 64'(exp_q.size() == 1));
            chk("dr_fill", 64'(fill), 64'(exp_q.size()));
            chk("dr_state", 64'(state), 64'd3);
            step();
            if (rd_ready) exp_q.delete(0);
            cyc++;
        end
        rd_ready = 1'b0;
        arm      = 1'b0;
        chk("drain_timeout", 64'(cyc >= 200), 64'd0);
        chk("end_state", 64'(state), 64'd0);
        chk("end_valid", 64'(rd_valid), 64'd0);
        chk("end_last", 64'(rd_last), 64'd0);
    endtask

    initial begin
        logic [REC_W-1:0] r;
        clr = 1'b0; arm = 1'b0; arm0 = 1'b0; rd_ready = 1'b0; rd_ready0 = 1'b0;
        bus = '0; ctrl_state = '0; mem_address_data = '0; instruction_data = '0;
        trig_mask = 16'hFFFF; trig_value = 16'h1234;
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_last", 64'(rd_last), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        clr = 1'b1;
        step();

        capture(2, 1'b1, 1'b0);
        chk("t1_fill", 64'(fill), 64'd7);
        drain(0);

        capture(30, 1'b0, 1'b1);
        chk("wrap_fill", 64'(fill), 64'd16);
        drain(2);

        capture(5, 1'b0, 1'b1);
        drain(1);

        trig_mask = 16'h0000;
        capture(0, 1'b0, 1'b0);
        drain(2);

        arm0 = 1'b1;
        step();
        arm0 = 1'b0;
        drive_taps(CTRL_W'($urandom));
        r = rec(1'b1);
        step();
        chk("p0_state", 64'(state0), 64'd3);
        chk("p0_fill", 64'(fill0), 64'd1);
        chk("p0_valid", 64'(rd_valid0), 64'd1);
        chk("p0_data", 64'(rd_data0), 64'(r));
        chk("p0_last", 64'(rd_last0), 64'd1);
        rd_ready0 = 1'b1;
        step();
        rd_ready0 = 1'b0;
        chk("p0_end_state", 64'(state0), 64'd0);
        chk("p0_end_valid", 64'(rd_valid0), 64'd0);

        trig_mask = 16'hFFFF;
        arm = 1'b1;
        step();
        arm = 1'b0;
        drive_taps(nonmatch());
        step();
        drive_taps(trig_value);
        step();
        drive_taps(CTRL_W'($urandom));
        step();
        chk("clr_pre_state", 64'(state), 64'd2);
        #3 clr = 1'b0;
        #1;
        chk("clr_state", 64'(state), 64'd0);
        chk("clr_fill", 64'(fill), 64'd0);
        chk("clr_valid", 64'(rd_valid), 64'd0);
        chk("clr_data", 64'(rd_data), 64'd0);
        #1 clr = 1'b1;
        step();
        capture(3, 1'b0, 1'b1);
        drain(2);

        repeat (4) begin
            capture(int'($urandom_range(0, 25)), 1'b0, 1'b1);
            drain(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sap_trace_buffer.md
# sap_trace_buffer

Parametrised logic-analyser block for the SAP-class CPU. It taps the CPU's bus, control word, memory address register and instruction register, and records one sample per clock into a ring buffer while armed. On a masked match of the control word it captures a fixed number of post-trigger samples, then freezes. Captured records drain oldest-first over a valid/ready port. It replaces fixed-length `$monitor` dumps with an in-design, trigger-driven capture.

## Interface
- `BUS_W`, 8, width of `bus` and `instruction_data`
- `CTRL_W`, 16, width of `ctrl_state`, `trig_mask`, `trig_value`
- `ADDR_W`, 4, width of `mem_address_data`
- `DEPTH`, 16, buffer entries; power of two, ≥ 2
- `POST_SAMPLES`, 4, samples stored after the trigger sample; range 0..DEPTH-1
- Derived: `REC_W` = 1+ADDR_W+2*BUS_W+CTRL_W; `CNT_W` = clog2(DEPTH)+1

Ports:
- `clk` in 1: single clock, rising edge
- `clr` in 1: reset, asynchronous, active-low
- `bus` in BUS_W: CPU bus tap
- `ctrl_state` in CTRL_W: control word tap
- `mem_address_data` in ADDR_W: MAR tap
- `instruction_data` in BUS_W: IR tap
- `arm` in 1: start capture; honoured only in IDLE
- `trig_mask` in CTRL_W, `trig_value` in CTRL_W: trigger when `(ctrl_state & trig_mask) == (trig_value & trig_mask)`
- `rd_ready` in 1: consumer accepts record
- `rd_valid` out 1: record available
- `rd_data` out REC_W: {trig_flag, mem_address_data, instruction_data, bus, ctrl_state}, trig_flag at MSB
- `rd_last` out 1: final record of the capture
- `state` out 2: 0 IDLE, 1 ARMED, 2 POST, 3 DRAIN
- `fill` out CNT_W: records held, 0..DEPTH

## Operation
- Reset (`clr` low, effective immediately): `state`=IDLE, `fill`=0, write/read pointers 0, post counter 0, `rd_valid`=0, `rd_last`=0, `rd_data`=0. Buffer contents need not be cleared.
- IDLE: no writes. `arm`=1 at an edge moves to ARMED and clears `fill` and the write pointer.
- ARMED: every edge writes the sample {match, taps} at wr_ptr; wr_ptr increments modulo DEPTH; `fill` increments, saturating at DEPTH (oldest entry overwritten). If match=1 on that edge: POST_SAMPLES=0 → DRAIN, else → POST with counter=POST_SAMPLES.
- POST: every edge writes a sample with trig_flag=0, regardless of match, and decrements the counter. The write that takes the counter to 0 moves to DRAIN. Wrap and saturation rules are as in ARMED.
- DRAIN: no writes. Read pointer starts at (wr_ptr − fill) mod DEPTH. `rd_valid`=1 while fill>0. `rd_data` is the entry at rd_ptr, read combinationally. On an edge with `rd_valid & rd_ready`: rd_ptr++ and fill−−. `rd_last`=1 when fill==1. The transfer with fill==1 moves to IDLE.
- `arm` outside IDLE is ignored. Only the first match per capture sets trig_flag.
- `rd_data` and `rd_valid` hold stable while `rd_ready`=0.

## Timing
- Arm latency: arm edge E0 → first sample written at E0+1.
- Trigger-to-freeze: trigger sample at edge T → DRAIN after edge T+POST_SAMPLES. `rd_valid` is high from that same edge.
- Throughput: one sample per clock while capturing, one record per clock while draining with `rd_ready` held high.
- Records per capture = min(samples written, DEPTH). Total written = pre-trigger samples + 1 + POST_SAMPLES.
- `clr` asserted mid-capture or mid-drain: outputs take their reset values asynchronously. The first `arm` after release starts a clean capture.

## Test plan
- Defaults, mask=16'hFFFF, value=16'h1234; arm, then present ctrl_state 0,1,0x1234 on samples 0–2, then POST → DRAIN 4 edges later; fill=7. Read 7 records in order; trig_flag set only on record 2; rd_last only on record 6; state returns to IDLE.
- Wraparound: trigger on sample 30, POST=4 → fill=16; records are samples 19..34 oldest-first; trig_flag on record 11.
- mask=0 → trigger on first sample; POST_SAMPLES=0 build → single record with trig_flag=1 and rd_last=1.
- Backpressure: drive rd_ready as 1,0,0,1,0,1… during drain → every record delivered once, in order; rd_data stable while stalled.
- `arm` pulsed during ARMED, POST and DRAIN → no state or pointer change.
- `clr` pulled low for a fraction of a cycle during POST → state=0, rd_valid=0, fill=0 immediately; a re-arm then captures correctly.
